data_sram_bridge: RTL

Data-side memory bridge sitting directly downstream of the Mem stage. It turns the Mem stage's single-cycle request (chip enable, write enable, address, byte-select, store data) into a two-phase request/address-ok/data-ok transaction on the SoC data SRAM-like bus. It stalls the pipeline until the transaction completes and returns the full 32-bit read word, from which the Mem stage extracts bytes and halfwords.

---
 rtl/data_sram_bridge_pkg.sv | 30 +++
 rtl/data_sram_bridge_sel_decode.sv | 30 +++
 rtl/data_sram_bridge.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/data_sram_bridge_pkg.sv
// data_sram_bridge_pkg
//   Shared definitions for the data-side SRAM bridge and its byte-select
//   decoder: FSM state encoding, bus size codes and the legal byte-select
//   patterns coming out of the Mem stage.
package data_sram_bridge_pkg;

  // Bridge FSM states (2-bit encoding).
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Bus transfer size codes.
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Legal byte-select patterns. Anything else (including 4'b0000, used by
  // the Mem stage to flag a misaligned store) is a null access.
  localparam logic [3:0] SEL_B0 = 4'b0001;
  localparam logic [3:0] SEL_B1 = 4'b0010;
  localparam logic [3:0] SEL_B2 = 4'b0100;
  localparam logic [3:0] SEL_B3 = 4'b1000;
  localparam logic [3:0] SEL_H0 = 4'b0011;
  localparam logic [3:0] SEL_H1 = 4'b1100;
  localparam logic [3:0] SEL_W  = 4'b1111;

endpackage

// File: rtl/data_sram_bridge_sel_decode.sv
// dsram_sel_decode
//   Purely combinational decode of a Mem-stage byte-select into
//   {valid, size}. Shared between the data-side and instruction-side bridges.
// Ports:
//   sel_i   : byte-select from the pipeline
//   valid_o : 1 when sel_i is one of the legal patterns
//   size_o  : bus size code (byte/half/word); SIZE_BYTE when invalid
module dsram_sel_decode
  import data_sram_bridge_pkg::*;
(
  input  logic [3:0] sel_i,
  output logic       valid_o,
  output logic [1:0] size_o
);

  always_comb begin
    valid_o = 1'b1;
    size_o  = SIZE_BYTE;
    case (sel_i)
      SEL_B0, SEL_B1, SEL_B2, SEL_B3: size_o = SIZE_BYTE;
      SEL_H0, SEL_H1:                 size_o = SIZE_HALF;
      SEL_W:                          size_o = SIZE_WORD;
      default: begin
        valid_o = 1'b0;
        size_o  = SIZE_BYTE;
      end
    endcase
  end

endmodule

// File: rtl/data_sram_bridge.sv
// data_sram_bridge
//   Converts the Mem stage's single-cycle access into a req/addr_ok/data_ok
//   transaction on the data SRAM-like bus, stalling the pipeline until the
//   transaction completes and returning the full read word.
//
//   Bus handshake: a request is offered while sram_req_o=1 and is accepted
//   in any cycle where sram_addr_ok_i=1 is seen alongside it; the request
//   fields stay constant from the first req cycle until that acceptance.
//   Completion is the first sram_data_ok_i=1 after acceptance. Only one
//   transaction is ever outstanding, and handshake inputs seen in a state
//   that is not waiting for them are ignored.
//
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   mem_*_i             : Mem-stage request (ce, we, addr, sel, wdata)
//   stall_i             : pipeline held by another source
//   mem_rdata_o         : read word, valid only in DONE (0 otherwise)
//   stall_req_o         : hold IF..Mem while the transaction is in flight
//   sram_*_o            : bus request side
//   sram_addr_ok_i      : request accepted
//   sram_data_ok_i      : read data valid / write complete
//   sram_rdata_i        : bus read data
module data_sram_bridge
  import data_sram_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              stall_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              stall_req_o,
  output logic              sram_req_o,
  output logic              sram_wr_o,
  output logic [1:0]        sram_size_o,
  output logic [3:0]        sram_wstrb_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_wdata_o,
  input  logic              sram_addr_ok_i,
  input  logic              sram_data_ok_i,
  input  logic [DATA_W-1:0] sram_rdata_i
);

  logic       sel_valid;
  logic [1:0] sel_size;
  logic       valid_access;

  dsram_sel_decode u_sel_decode (
    .sel_i   (mem_sel_i),
    .valid_o (sel_valid),
    .size_o  (sel_size)
  );

  assign valid_access = mem_ce_i & sel_valid;

  // Request fields as they would appear on the bus straight from the inputs.
  logic [3:0] in_wstrb;
  assign in_wstrb = mem_we_i ? mem_sel_i : 4'b0000;

  state_e              state_q, state_d;
  logic                wr_q, wr_d;
  logic [1:0]          size_q, size_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    wstrb_d = wstrb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (valid_access) begin
          // Latch the request so REQ keeps it stable even if inputs move.
          wr_d    = mem_we_i;
          size_d  = sel_size;
          wstrb_d = in_wstrb;
          addr_d  = mem_addr_i;
          wdata_d = mem_wdata_i;
          state_d = sram_addr_ok_i ? ST_WAIT : ST_REQ;
        end
      end
      ST_REQ: begin
        if (sram_addr_ok_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (sram_data_ok_i) begin
          state_d = ST_DONE;
          rdata_d = wr_q ? '0 : sram_rdata_i;
        end
      end
      ST_DONE: begin
        if (!stall_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      size_q  <= SIZE_BYTE;
      wstrb_q <= 4'b0000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      wstrb_q <= wstrb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // In IDLE the bus is driven straight from the inputs (zeroed for a null or
  // absent access) so the first request goes out with no added latency.
  // Elsewhere the latched fields are shown.
  always_comb begin
    sram_req_o   = 1'b0;
    sram_wr_o    = wr_q;
    sram_size_o  = size_q;
    sram_wstrb_o = wstrb_q;
    sram_addr_o  = addr_q;
    sram_wdata_o = wdata_q;
    if (state_q == ST_IDLE) begin
      sram_req_o   = valid_access;
      sram_wr_o    = valid_access ? mem_we_i    : 1'b0;
      sram_size_o  = valid_access ? sel_size    : SIZE_BYTE;
      sram_wstrb_o = valid_access ? in_wstrb    : 4'b0000;
      sram_addr_o  = valid_access ? mem_addr_i  : '0;
      sram_wdata_o = valid_access ? mem_wdata_i : '0;
    end else if (state_q == ST_REQ) begin
      sram_req_o = 1'b1;
    end
  end

  assign stall_req_o = ((state_q == ST_IDLE) && valid_access) ||
                       (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign mem_rdata_o = (state_q == ST_DONE) ? rdata_q : '0;

endmodule
